axi_wr_slave: RTL and testbench

AXI_WR_SLAVE -- requirements
Module: axi_wr_slave

---
 rtl/axi_pkg.sv | 23 ++
 rtl/axi_slave_ram.sv | 35 +++
 rtl/axi_wr_slave.sv | 182 ++++++++++++++++++
 tb/tb_axi_wr_slave.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared definitions for the AXI write slave: FSM encoding, BRESP and burst codes.
// Beat-level error rule is kept here so every user agrees on it.
package axi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR   = 2'b01;

  // A beat is bad when WLAST disagrees with its position or WID is not the burst's ID.
  function automatic logic beat_error(input logic       wlast,
                                      input logic       is_last,
                                      input logic [7:0] wid,
                                      input logic [7:0] aid);
    return (wlast != is_last) || (wid != aid);
  endfunction

endpackage

// File: rtl/axi_slave_ram.sv
// Beat-wide storage for the AXI write slave: byte-enable write port and a
// registered read port that returns pre-write data on a same-cycle collision.
module axi_slave_ram #(
  parameter  int DATA_WIDTH = 256,
  parameter  int DEPTH      = 64,
  localparam int AW         = $clog2(DEPTH),
  localparam int NB         = DATA_WIDTH / 8
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [NB-1:0]         i_wstrb,
  input  logic [AW-1:0]         i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Contents are deliberately not reset; the read register sees the old word.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < NB; b++) begin
        if (i_wstrb[b]) begin
          mem_q[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end
    rdata_q <= mem_q[i_raddr];
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/axi_wr_slave.sv
// AXI write-only slave with an internal wrap-around memory and debug readback.
// Define AXI_WR_SLAVE_BACKPRESSURE_EN to stall WREADY one cycle after every 4th beat.
module axi_wr_slave
  import axi_pkg::*;
#(
  parameter  int                    DATA_WIDTH = 256,
  parameter  int                    ADDR_WIDTH = 32,
  parameter  int                    MEM_DEPTH  = 64,
  parameter  logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'h00000000),
  localparam int                    IDX_W      = $clog2(MEM_DEPTH),
  localparam int                    NB         = DATA_WIDTH / 8,
  localparam int                    LANE_SHIFT = $clog2(NB)
) (
  input  logic                  i_axi_clk,
  input  logic                  i_rstn,
  input  logic [7:0]            i_aid,
  input  logic [ADDR_WIDTH-1:0] i_aaddr,
  input  logic [7:0]            i_alen,
  input  logic [2:0]            i_asize,
  input  logic [1:0]            i_aburst,
  input  logic [1:0]            i_alock,
  input  logic                  i_avalid,
  input  logic                  i_atype,
  output logic                  o_aready,
  input  logic [7:0]            i_wid,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [NB-1:0]         i_wstrb,
  input  logic                  i_wlast,
  input  logic                  i_wvalid,
  output logic                  o_wready,
  output logic [7:0]            o_bid,
  output logic [1:0]            o_bresp,
  output logic                  o_bvalid,
  input  logic                  i_bready,
  input  logic [IDX_W-1:0]      i_dbg_addr,
  output logic [DATA_WIDTH-1:0] o_dbg_data,
  output logic [15:0]           o_burst_cnt,
  output logic [1:0]            o_states
);

  state_e          state_q, state_d;
  logic [7:0]      aid_q, aid_d;
  logic [7:0]      alen_q, alen_d;
  logic [7:0]      beat_q, beat_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic            err_q, err_d;
  logic            stall_q, stall_d;
  logic [15:0]     bcnt_q, bcnt_d;

  logic [ADDR_WIDTH-1:0] offset_s;
  logic [IDX_W-1:0]      start_idx_s;
  logic                  aw_hs_s, w_hs_s, b_hs_s, last_beat_s;
  logic                  unused_s;

  assign offset_s    = i_aaddr - BASE_ADDR;
  assign start_idx_s = offset_s[LANE_SHIFT +: IDX_W];
  assign aw_hs_s     = i_avalid & o_aready;
  assign w_hs_s      = i_wvalid & o_wready;
  assign b_hs_s      = o_bvalid & i_bready;
  assign last_beat_s = (beat_q == alen_q);
  assign unused_s    = ^{i_alock, i_asize, offset_s};

  // State and burst bookkeeping registers.
  always_ff @(posedge i_axi_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= ST_IDLE;
      aid_q   <= 8'd0;
      alen_q  <= 8'd0;
      beat_q  <= 8'd0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      stall_q <= 1'b0;
      bcnt_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      aid_q   <= aid_d;
      alen_q  <= alen_d;
      beat_q  <= beat_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      stall_q <= stall_d;
      bcnt_q  <= bcnt_d;
    end
  end

  // Next-state logic: the burst ends on beat count alone, never on WLAST.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = aw_hs_s ? ST_DATA : ST_IDLE;
      ST_DATA: state_d = (w_hs_s && last_beat_s) ? ST_RESP : ST_DATA;
      ST_RESP: state_d = b_hs_s ? ST_IDLE : ST_RESP;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: capture on AW, advance per beat, count on B.
  always_comb begin
    aid_d   = aid_q;
    alen_d  = alen_q;
    beat_d  = beat_q;
    idx_d   = idx_q;
    err_d   = err_q;
    stall_d = stall_q;
    bcnt_d  = bcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (aw_hs_s) begin
          aid_d   = i_aid;
          alen_d  = i_alen;
          idx_d   = start_idx_s;
          beat_d  = 8'd0;
          err_d   = (i_aburst != BURST_INCR);
          stall_d = 1'b0;
        end else begin
          stall_d = 1'b0;
        end
      end
      ST_DATA: begin
        stall_d = 1'b0;
        if (w_hs_s) begin
          idx_d  = idx_q + IDX_W'(1);
          beat_d = beat_q + 8'd1;
          err_d  = err_q | beat_error(i_wlast, last_beat_s, i_wid, aid_q);
`ifdef AXI_WR_SLAVE_BACKPRESSURE_EN
          stall_d = (beat_q[1:0] == 2'b11) & ~last_beat_s;
`else
          stall_d = 1'b0;
`endif
        end else begin
          stall_d = 1'b0;
        end
      end
      ST_RESP: begin
        if (b_hs_s) begin
          bcnt_d = bcnt_q + 16'd1;
        end else begin
          bcnt_d = bcnt_q;
        end
      end
      default: begin
        stall_d = 1'b0;
      end
    endcase
  end

  // Handshake outputs decoded from registered state.
  always_comb begin
    o_aready = 1'b0;
    o_wready = 1'b0;
    o_bvalid = 1'b0;
    o_bid    = 8'd0;
    o_bresp  = BRESP_OKAY;
    case (state_q)
      ST_IDLE: o_aready = i_atype;
      ST_DATA: o_wready = ~stall_q;
      ST_RESP: begin
        o_bvalid = 1'b1;
        o_bid    = aid_q;
        o_bresp  = err_q ? BRESP_SLVERR : BRESP_OKAY;
      end
      default: o_aready = 1'b0;
    endcase
  end

  assign o_burst_cnt = bcnt_q;
  assign o_states    = state_q;

  axi_slave_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MEM_DEPTH)
  ) u_ram (
    .i_clk   (i_axi_clk),
    .i_we    (w_hs_s),
    .i_waddr (idx_q),
    .i_wdata (i_wdata),
    .i_wstrb (i_wstrb),
    .i_raddr (i_dbg_addr),
    .o_rdata (o_dbg_data)
  );

endmodule

// File: tb/tb_axi_wr_slave.sv
// Randomised bench for axi_wr_slave with a transaction-level reference model
// and a per-cycle compare process; directed cases pin the model with literals.
module tb_axi_wr_slave;

  localparam int          DW    = 256;
  localparam int          NB    = DW / 8;
  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h00000000;
`ifdef AXI_WR_SLAVE_BACKPRESSURE_EN
  localparam bit BP_EN = 1'b1;
`else
  localparam bit BP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          i_rstn;
  logic [7:0]    i_aid, i_alen, i_wid;
  logic [31:0]   i_aaddr;
  logic [2:0]    i_asize;
  logic [1:0]    i_aburst, i_alock;
  logic          i_avalid, i_atype, i_wlast, i_wvalid, i_bready;
  logic [DW-1:0] i_wdata;
  logic [NB-1:0] i_wstrb;
  logic [5:0]    i_dbg_addr;
  logic          o_aready, o_wready, o_bvalid;
  logic [7:0]    o_bid;
  logic [1:0]    o_bresp;
  logic [DW-1:0] o_dbg_data;
  logic [15:0]   o_burst_cnt;
  logic [1:0]    o_states;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  axi_wr_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(32), .MEM_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .i_axi_clk(clk), .i_rstn(i_rstn),
    .i_aid(i_aid), .i_aaddr(i_aaddr), .i_alen(i_alen), .i_asize(i_asize),
    .i_aburst(i_aburst), .i_alock(i_alock), .i_avalid(i_avalid), .i_atype(i_atype),
    .o_aready(o_aready),
    .i_wid(i_wid), .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wlast(i_wlast),
    .i_wvalid(i_wvalid), .o_wready(o_wready),
    .o_bid(o_bid), .o_bresp(o_bresp), .o_bvalid(o_bvalid), .i_bready(i_bready),
    .i_dbg_addr(i_dbg_addr), .o_dbg_data(o_dbg_data),
    .o_burst_cnt(o_burst_cnt), .o_states(o_states)
  );

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 data, 2 response.
  logic [DW-1:0] mem_m [DEPTH];
  bit            known_m [DEPTH];
  int            m_phase = 0, m_len = 0, m_beat = 0, m_idx = 0;
  logic [7:0]    m_aid = 8'd0;
  bit            m_err = 1'b0, m_stall = 1'b0, m_dbg_known = 1'b0;
  logic [15:0]   m_bcnt = 16'd0;
  logic [DW-1:0] m_dbg_exp;

  always @(posedge clk) begin
    m_dbg_known = i_rstn && known_m[i_dbg_addr];
    m_dbg_exp   = mem_m[i_dbg_addr];
    if (!i_rstn) begin
      m_phase = 0; m_err = 1'b0; m_stall = 1'b0; m_bcnt = 16'd0;
    end else if (m_phase == 0) begin
      if (i_avalid && i_atype) begin
        logic [31:0] off;
        off     = i_aaddr - BASE;
        m_idx   = int'((off >> 5) % DEPTH);
        m_aid   = i_aid;
        m_len   = int'(i_alen);
        m_beat  = 0;
        m_err   = (i_aburst != 2'b01);
        m_stall = 1'b0;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (m_stall) begin
        m_stall = 1'b0;
      end else if (i_wvalid) begin
        for (int b = 0; b < NB; b++)
          if (i_wstrb[b]) mem_m[m_idx][b*8 +: 8] = i_wdata[b*8 +: 8];
        known_m[m_idx] = known_m[m_idx] | (&i_wstrb);
        if (i_wlast != (m_beat == m_len)) m_err = 1'b1;
        if (i_wid != m_aid) m_err = 1'b1;
        m_idx  = (m_idx + 1) % DEPTH;
        m_beat = m_beat + 1;
        if (m_beat == m_len + 1) m_phase = 2;
        else m_stall = BP_EN && (m_beat % 4 == 0);
      end
    end else begin
      if (i_bready) begin
        m_phase = 0;
        m_bcnt  = m_bcnt + 16'd1;
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (!i_rstn) begin
      chk("rst_wready", o_wready, 0);
      chk("rst_bvalid", o_bvalid, 0);
      chk("rst_bresp", o_bresp, 0);
      chk("rst_bid", o_bid, 0);
      chk("rst_burst_cnt", o_burst_cnt, 0);
      chk("rst_state", o_states, 0);
    end else begin
      chk("aready", o_aready, (m_phase == 0) && i_atype);
      chk("wready", o_wready, (m_phase == 1) && !m_stall);
      chk("bvalid", o_bvalid, m_phase == 2);
      if (m_phase == 2) begin
        chk("bid", o_bid, m_aid);
        chk("bresp", o_bresp, m_err ? 2'b10 : 2'b00);
      end
      chk("burst_cnt", o_burst_cnt, m_bcnt);
      chk("state", o_states, m_phase);
      if (m_dbg_known) chk("dbg_data", o_dbg_data, m_dbg_exp);
    end
  end

  logic [DW-1:0] beat_data [256];
  logic [NB-1:0] beat_strb [256];

  // All tasks start and end just after a rising edge.
  task automatic send_burst(input logic [7:0] aid, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input int gap_pct, input int bad_last,
                            input bit wid_bad, input int abort_after, input bit rnd_dbg,
                            output int dcyc);
    bit ok;
    int b, guard;
    dcyc = 0; ok = 1'b0;
    i_aid = aid; i_aaddr = addr; i_alen = len; i_aburst = burst;
    i_asize = 3'($urandom_range(7)); i_alock = 2'($urandom_range(3));
    i_avalid = 1'b1; i_atype = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk); ok = o_aready;
      @(posedge clk); #1;
      if (ok) break;
    end
    i_avalid = 1'b0;
    chk("aw_handshake", ok, 1);
    if (!ok) return;
    b = 0; guard = 0;
    while (b <= int'(len) && b != abort_after && guard < 3000) begin
      i_wvalid = ($urandom_range(99) >= gap_pct);
      i_wdata  = beat_data[b];
      i_wstrb  = beat_strb[b];
      i_wlast  = (b == int'(len)) ^ (b == bad_last);
      i_wid    = wid_bad ? (aid ^ 8'h01) : aid;
      if (rnd_dbg) i_dbg_addr = 6'($urandom_range(63));
      @(negedge clk);
      if (o_states == 2'd1) dcyc++;
      ok = i_wvalid && o_wready;
      @(posedge clk); #1;
      if (ok) b++;
      guard++;
    end
    i_wvalid = 1'b0;
    chk("w_budget", guard < 3000, 1);
  endtask

  task automatic take_resp(input int hold, output logic [7:0] bid, output logic [1:0] bresp);
    bit ok;
    ok = 1'b0; i_bready = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk); ok = o_bvalid;
      @(posedge clk); #1;
      if (ok) break;
    end
    chk("bvalid_seen", ok, 1);
    repeat (hold) begin @(posedge clk); #1; end
    i_bready = 1'b1;
    @(negedge clk);
    chk("bvalid_held", o_bvalid, 1);
    bid = o_bid; bresp = o_bresp;
    @(posedge clk); #1;
    i_bready = 1'b0;
  endtask

  task automatic rd_dbg(input logic [5:0] a, input logic [DW-1:0] exp, input string nm);
    i_dbg_addr = a;
    @(posedge clk); @(negedge clk);
    chk(nm, o_dbg_data, exp);
    @(posedge clk); #1;
  endtask

  task automatic fill_random(input int n, input bit full);
    for (int k = 0; k < n; k++) begin
      beat_data[k] = {8{$urandom()}};
      beat_strb[k] = full ? {NB{1'b1}} : NB'($urandom());
    end
  endtask

  initial begin
    logic [7:0]  bid;
    logic [1:0]  bresp;
    int          dc;
    logic [DW-1:0] hi_f;
    i_rstn = 1'b0; i_aid = 8'd0; i_aaddr = 32'd0; i_alen = 8'd0; i_asize = 3'd5;
    i_aburst = 2'b01; i_alock = 2'b00; i_avalid = 1'b0; i_atype = 1'b0;
    i_wid = 8'd0; i_wdata = '0; i_wstrb = '0; i_wlast = 1'b0; i_wvalid = 1'b0;
    i_bready = 1'b0; i_dbg_addr = 6'd0;
    repeat (3) @(posedge clk);
    #1 i_rstn = 1'b1;
    @(posedge clk); #1;

    // Give every memory word a known value, then reset to clear the counter.
    fill_random(64, 1'b1);
    send_burst(8'h00, BASE, 8'd63, 2'b01, 0, -1, 1'b0, -1, 1'b0, dc);
    take_resp(0, bid, bresp);
    i_rstn = 1'b0; @(posedge clk); #1; i_rstn = 1'b1; @(posedge clk); #1;

    // 16-beat burst of 1..16 from address 0.
    for (int k = 0; k < 16; k++) begin
      beat_data[k] = DW'(k + 1); beat_strb[k] = {NB{1'b1}};
    end
    send_burst(8'h5A, 32'd0, 8'd15, 2'b01, 0, -1, 1'b0, -1, 1'b0, dc);
    chk("data_cycles_16", dc, BP_EN ? 19 : 16);
    take_resp(0, bid, bresp);
    chk("b26_bid", bid, 8'h5A);
    chk("b26_bresp", bresp, 2'b00);
    @(negedge clk); chk("b26_burst_cnt", o_burst_cnt, 16'd1);
    @(posedge clk); #1;
    for (int k = 0; k < 16; k++) rd_dbg(6'(k), DW'(k + 1), "b26_dbg");

    // Wrap-around from word 62.
    fill_random(4, 1'b1);
    send_burst(8'h03, DEPTH * 32 - 64, 8'd3, 2'b01, 0, -1, 1'b0, -1, 1'b0, dc);
    take_resp(0, bid, bresp);
    chk("wrap_bresp", bresp, 2'b00);
    rd_dbg(6'd62, beat_data[0], "wrap_w62");
    rd_dbg(6'd63, beat_data[1], "wrap_w63");
    rd_dbg(6'd0,  beat_data[2], "wrap_w0");
    rd_dbg(6'd1,  beat_data[3], "wrap_w1");

    // Partial strobes over an all-ones word.
    beat_data[0] = '1; beat_strb[0] = {NB{1'b1}};
    send_burst(8'h10, 32'd320, 8'd0, 2'b01, 0, -1, 1'b0, -1, 1'b0, dc);
    take_resp(0, bid, bresp);
    beat_data[0] = '0; beat_strb[0] = 32'h0000FFFF;
    send_burst(8'h11, 32'd320, 8'd0, 2'b01, 0, -1, 1'b0, -1, 1'b0, dc);
    take_resp(0, bid, bresp);
    chk("strb_bresp", bresp, 2'b00);
    hi_f = {{128{1'b1}}, {128{1'b0}}};
    rd_dbg(6'd10, hi_f, "strb_word10");

    // Early WLAST and WID mismatch both complete all 8 beats with SLVERR.
    fill_random(8, 1'b0);
    send_burst(8'h21, 32'd640, 8'd7, 2'b01, 0, 3, 1'b0, -1, 1'b0, dc);
    take_resp(0, bid, bresp);
    chk("early_last_bresp", bresp, 2'b10);
    chk("early_last_bid", bid, 8'h21);
    send_burst(8'h22, 32'd640, 8'd7, 2'b01, 0, -1, 1'b1, -1, 1'b0, dc);
    take_resp(0, bid, bresp);
    chk("wid_bad_bresp", bresp, 2'b10);

    // Read requests are never accepted.
    i_avalid = 1'b1; i_atype = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("read_aready", o_aready, 0);
      chk("read_state", o_states, 2'd0);
      @(posedge clk); #1;
    end
    i_avalid = 1'b0;

    // BREADY held low for five cycles.
    fill_random(1, 1'b1);
    send_burst(8'h77, 32'd64, 8'd0, 2'b01, 0, -1, 1'b0, -1, 1'b0, dc);
    take_resp(4, bid, bresp);
    chk("hold_bid", bid, 8'h77);
    chk("hold_bresp", bresp, 2'b00);

    // Reset after five beats of a 16-beat burst.
    fill_random(16, 1'b1);
    send_burst(8'h44, 32'd0, 8'd15, 2'b01, 0, -1, 1'b0, 5, 1'b0, dc);
    i_rstn = 1'b0;
    #1;
    chk("mid_rst_wready", o_wready, 0);
    chk("mid_rst_bvalid", o_bvalid, 0);
    chk("mid_rst_state", o_states, 2'd0);
    @(posedge clk); #1; i_rstn = 1'b1; @(posedge clk); #1;

    // Randomised bursts with gaps, bad bursts and random debug reads.
    for (int n = 0; n < 30; n++) begin
      int len, bad;
      logic [1:0] bt;
      len = $urandom_range(20);
      fill_random(len + 1, $urandom_range(1) == 1);
      bt  = ($urandom_range(9) == 0) ? 2'($urandom_range(3)) : 2'b01;
      bad = ($urandom_range(5) == 0) ? $urandom_range(len) : -1;
      send_burst(8'($urandom()), $urandom(), 8'(len), bt, 25, bad,
                 $urandom_range(7) == 0, -1, 1'b1, dc);
      take_resp($urandom_range(3), bid, bresp);
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
